// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP stream engine.
//   clog2      : ceiling log2, used to size address and counter fields
//   NB_*       : bit positions of each neighbour inside the 8-bit LBP code
//   state_t    : frame-level FSM states
package lbp_pkg;

  // Ceiling log2 of v (v >= 1); clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Code bit positions, raster order around the centre.
  localparam int NB_TL = 0;
  localparam int NB_T  = 1;
  localparam int NB_TR = 2;
  localparam int NB_L  = 3;
  localparam int NB_R  = 4;
  localparam int NB_BL = 5;
  localparam int NB_B  = 6;
  localparam int NB_BR = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/lbp_line_buffer.sv
// One-row delay line: dout is the value written DEPTH enables ago.
// Implemented as a circular buffer; contents are not reset.
//   clk, rst : clock, async active-high reset (pointer only)
//   en       : advance one position (write din, present next oldest)
//   din/dout : DW-bit pixel in / DEPTH-delayed pixel out
module lbp_line_buffer
  import lbp_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_P = PW'(DEPTH - 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;

  // The slot about to be overwritten holds the oldest sample.
  assign dout = mem_q[ptr_q];

  // Next pointer: wrap after the last slot.
  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      if (ptr_q == LAST_P) ptr_d = '0;
      else                 ptr_d = ptr_q + PW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (en) mem_q[ptr_q] <= din;
  end

endmodule

// File: rtl/lbp_stream_engine.sv
// Raster-scan Local Binary Pattern engine.
// Reads every grey pixel once, forms a 3x3 window from two line buffers and
// writes one LBP code per pixel position, then holds finish until reset.
//   clk, reset        : clock, async active-high reset
//   gray_ready/req    : source available / read strobe (combinational)
//   gray_addr/data    : raster read address / pixel returned one cycle later
//   lbp_valid/addr/data : code write strobe, raster address, 8-bit code
//   finish            : frame complete, sticky
module lbp_stream_engine
  import lbp_pkg::*;
#(
  parameter int IMG_W       = 128,
  parameter int IMG_H       = 128,
  parameter int DW          = 8,
  parameter int THRESH      = 0,
  parameter int BORDER_ZERO = 1,
  localparam int AW         = clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [DW-1:0] gray_data,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic [7:0]    lbp_data,
  output logic          finish
);

  localparam int RW = clog2(IMG_H);
  localparam int CW = clog2(IMG_W);
  localparam logic [AW:0]   N_C     = (AW+1)'(IMG_W * IMG_H);
  localparam logic [AW:0]   PRIME_C = (AW+1)'(IMG_W + 1);
  localparam logic [AW-1:0] LAST_C  = AW'(IMG_W * IMG_H - 1);
  localparam logic [RW-1:0] LROW_C  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] LCOL_C  = CW'(IMG_W - 1);
  localparam logic [DW:0]   THR_C   = (DW+1)'(THRESH);

  state_t              state_q, state_d;
  logic [AW-1:0]       rd_addr_q, rd_addr_d;
  logic                cap_en_q, cap_en_d;
  logic [AW:0]         cap_cnt_q, cap_cnt_d;
  logic [AW:0]         slot_cnt_q, slot_cnt_d;
  logic                slot_q, slot_d;
  logic [AW-1:0]       oaddr_q, oaddr_d;
  logic [RW-1:0]       orow_q, orow_d;
  logic [CW-1:0]       ocol_q, ocol_d;
  logic [2:0][DW-1:0]  top_q, top_d, mid_q, mid_d, bot_q, bot_d;
  logic                lbp_valid_q, lbp_valid_d;
  logic [AW-1:0]       lbp_addr_q, lbp_addr_d;
  logic [7:0]          lbp_data_q, lbp_data_d;
  logic                last_wr_q, last_wr_d;
  logic                finish_q, finish_d;

  logic [DW-1:0]       lb1_out_s, lb2_out_s;
  logic [7:0][DW-1:0]  nb_s;
  logic [7:0]          code_s;
  logic                border_s;

  assign gray_req  = (state_q == ST_READ) && gray_ready;
  assign gray_addr = rd_addr_q;
  assign lbp_valid = lbp_valid_q;
  assign lbp_addr  = lbp_addr_q;
  assign lbp_data  = lbp_data_q;
  assign finish    = finish_q;

  // Row delays: lb1 gives the pixel one row up, lb2 two rows up.
  lbp_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
    .clk(clk), .rst(reset), .en(cap_en_q), .din(gray_data), .dout(lb1_out_s)
  );
  lbp_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb2 (
    .clk(clk), .rst(reset), .en(cap_en_q), .din(lb1_out_s), .dout(lb2_out_s)
  );

  // Window columns: index 0 = left (c-1), 1 = centre column, 2 = right (c+1).
  assign nb_s[NB_TL] = top_q[0];
  assign nb_s[NB_T]  = top_q[1];
  assign nb_s[NB_TR] = top_q[2];
  assign nb_s[NB_L]  = mid_q[0];
  assign nb_s[NB_R]  = mid_q[2];
  assign nb_s[NB_BL] = bot_q[0];
  assign nb_s[NB_B]  = bot_q[1];
  assign nb_s[NB_BR] = bot_q[2];

  // Neighbour compare, widened by one bit so ctr+THRESH cannot wrap.
  always_comb begin
    code_s = 8'h00;
    for (int k = 0; k < 8; k++) begin
      code_s[k] = ({1'b0, nb_s[k]} >= ({1'b0, mid_q[1]} + THR_C));
    end
    border_s = (orow_q == '0) || (orow_q == LROW_C) ||
               (ocol_q == '0) || (ocol_q == LCOL_C);
  end

  // Next-state logic: FSM, read address, window capture, output slot stage.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    cap_en_d    = gray_req;
    cap_cnt_d   = cap_cnt_q;
    slot_cnt_d  = slot_cnt_q;
    slot_d      = 1'b0;
    oaddr_d     = oaddr_q;
    orow_d      = orow_q;
    ocol_d      = ocol_q;
    top_d       = top_q;
    mid_d       = mid_q;
    bot_d       = bot_q;
    lbp_valid_d = 1'b0;
    lbp_addr_d  = lbp_addr_q;
    lbp_data_d  = lbp_data_q;
    last_wr_d   = 1'b0;
    finish_d    = finish_q | last_wr_q;

    case (state_q)
      ST_IDLE: begin
        if (gray_ready) state_d = ST_READ;
        else            state_d = ST_IDLE;
      end
      ST_READ: begin
        // Counter freezes on the last address; stalls simply hold it.
        if (gray_ready) begin
          if (rd_addr_q == LAST_C) state_d = ST_FLUSH;
          else                     rd_addr_d = rd_addr_q + AW'(1);
        end else begin
          state_d = ST_READ;
        end
      end
      ST_FLUSH: begin
        if (last_wr_q) state_d = ST_DONE;
        else           state_d = ST_FLUSH;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    // A capture of pixel k completes the window centred on k-(IMG_W+1);
    // once all pixels are in, the remaining (all border) slots are
    // produced one per cycle without window data.
    if (cap_en_q) begin
      top_d     = {lb2_out_s, top_q[2:1]};
      mid_d     = {lb1_out_s, mid_q[2:1]};
      bot_d     = {gray_data, bot_q[2:1]};
      cap_cnt_d = cap_cnt_q + (AW+1)'(1);
      slot_d    = (cap_cnt_q >= PRIME_C);
    end else begin
      slot_d = (state_q == ST_FLUSH) && (cap_cnt_q == N_C) && (slot_cnt_q != N_C);
    end
    if (slot_d) slot_cnt_d = slot_cnt_q + (AW+1)'(1);

    if (slot_q) begin
      lbp_valid_d = border_s ? (BORDER_ZERO != 0) : 1'b1;
      lbp_addr_d  = oaddr_q;
      lbp_data_d  = border_s ? 8'h00 : code_s;
      last_wr_d   = (oaddr_q == LAST_C);
      oaddr_d     = oaddr_q + AW'(1);
      if (ocol_q == LCOL_C) begin
        ocol_d = '0;
        orow_d = orow_q + RW'(1);
      end else begin
        ocol_d = ocol_q + CW'(1);
      end
    end else begin
      lbp_valid_d = 1'b0;
    end
  end

  // All engine state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      cap_en_q    <= 1'b0;
      cap_cnt_q   <= '0;
      slot_cnt_q  <= '0;
      slot_q      <= 1'b0;
      oaddr_q     <= '0;
      orow_q      <= '0;
      ocol_q      <= '0;
      top_q       <= '0;
      mid_q       <= '0;
      bot_q       <= '0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= 8'h00;
      last_wr_q   <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      cap_en_q    <= cap_en_d;
      cap_cnt_q   <= cap_cnt_d;
      slot_cnt_q  <= slot_cnt_d;
      slot_q      <= slot_d;
      oaddr_q     <= oaddr_d;
      orow_q      <= orow_d;
      ocol_q      <= ocol_d;
      top_q       <= top_d;
      mid_q       <= mid_d;
      bot_q       <= bot_d;
      lbp_valid_q <= lbp_valid_d;
      lbp_addr_q  <= lbp_addr_d;
      lbp_data_q  <= lbp_data_d;
      last_wr_q   <= last_wr_d;
      finish_q    <= finish_d;
    end
  end

endmodule

// File: tb/tb_lbp_stream_engine.sv
// Bench for lbp_stream_engine: two instances (8x6 border-zero, 6x5 silent
// border with THRESH=2), a synchronous grey memory per instance, a
// falling-edge write sink, and a reference LBP model computed directly from
// the neighbourhood definition.
module tb_lbp_stream_engine;

  localparam int WA = 8;
  localparam int HA = 6;
  localparam int NA = WA * HA;
  localparam int WB = 6;
  localparam int HB = 5;
  localparam int NB = WB * HB;
  localparam int TB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, ready_a, req_a, lv_a, fin_a;
  logic [5:0] gaddr_a, laddr_a;
  logic [7:0] gdata_a, ldata_a;
  logic       rst_b, ready_b, req_b, lv_b, fin_b;
  logic [4:0] gaddr_b, laddr_b;
  logic [7:0] gdata_b, ldata_b;

  logic [7:0] img_a [64];
  logic [7:0] img_b [64];
  logic [7:0] wdat_a [64];
  logic [7:0] wdat_b [64];
  int         wcnt_a [64];
  int         wcnt_b [64];
  logic       mon_a = 1'b0;
  int         stall_bad_a = 0;

  int checks = 0;
  int errors = 0;

  lbp_stream_engine #(.IMG_W(WA), .IMG_H(HA), .DW(8), .THRESH(0), .BORDER_ZERO(1)) dut_a (
    .clk(clk), .reset(rst_a), .gray_ready(ready_a), .gray_req(req_a), .gray_addr(gaddr_a),
    .gray_data(gdata_a), .lbp_valid(lv_a), .lbp_addr(laddr_a), .lbp_data(ldata_a), .finish(fin_a)
  );

  lbp_stream_engine #(.IMG_W(WB), .IMG_H(HB), .DW(8), .THRESH(TB), .BORDER_ZERO(0)) dut_b (
    .clk(clk), .reset(rst_b), .gray_ready(ready_b), .gray_req(req_b), .gray_addr(gaddr_b),
    .gray_data(gdata_b), .lbp_valid(lv_b), .lbp_addr(laddr_b), .lbp_data(ldata_b), .finish(fin_b)
  );

  // Synchronous grey memories: data for a request appears the next cycle.
  always @(posedge clk) begin
    if (req_a) gdata_a <= img_a[gaddr_a];
    if (req_b) gdata_b <= img_b[gaddr_b];
  end

  // Write sinks capture on the falling edge; stall monitor for instance A.
  always @(negedge clk) begin
    if (lv_a) begin
      wcnt_a[laddr_a] = wcnt_a[laddr_a] + 1;
      wdat_a[laddr_a] = ldata_a;
    end
    if (lv_b) begin
      wcnt_b[laddr_b] = wcnt_b[laddr_b] + 1;
      wdat_b[laddr_b] = ldata_b;
    end
    if (mon_a && (lv_a || req_a)) stall_bad_a = stall_bad_a + 1;
  end

  // Reference LBP code of raster index idx; borders give 0.
  function automatic logic [7:0] ref_code(input logic [7:0] im [64], input int w, input int h,
                                          input int th, input int idx);
    int dr [8];
    int dc [8];
    int r, c;
    logic [7:0] code;
    dr = '{-1, -1, -1, 0, 0, 1, 1, 1};
    dc = '{-1, 0, 1, -1, 1, -1, 0, 1};
    r = idx / w;
    c = idx % w;
    code = 8'h00;
    if (r == 0 || r == h - 1 || c == 0 || c == w - 1) return 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (int'(im[(r + dr[k]) * w + c + dc[k]]) >= int'(im[idx]) + th) code[k] = 1'b1;
    end
    return code;
  endfunction

  // Run one frame on A (optional 10-cycle stall starting at cycle stall_at).
  task automatic run_a(input int stall_at, output bit to, output int cyc,
                       output logic [5:0] a0, output logic [5:0] a1);
    for (int i = 0; i < 64; i++) begin
      wcnt_a[i] = 0;
      wdat_a[i] = 8'h00;
    end
    rst_a = 1'b1;
    ready_a = 1'b0;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    ready_a = 1'b1;
    cyc = 0;
    to = 1'b0;
    a0 = '0;
    a1 = '0;
    while (fin_a !== 1'b1 && !to) begin
      @(posedge clk);
      #1;
      cyc++;
      if (stall_at >= 0) begin
        if (cyc == stall_at)      ready_a = 1'b0;
        if (cyc == stall_at + 1)  a0 = gaddr_a;
        if (cyc == stall_at + 3)  mon_a = 1'b1;
        if (cyc == stall_at + 9)  a1 = gaddr_a;
        if (cyc == stall_at + 10) begin
          ready_a = 1'b1;
          mon_a = 1'b0;
        end
      end
      if (cyc > 3000) to = 1'b1;
    end
  endtask

  // Run one frame on B.
  task automatic run_b(output bit to, output int cyc);
    for (int i = 0; i < 64; i++) begin
      wcnt_b[i] = 0;
      wdat_b[i] = 8'h00;
    end
    rst_b = 1'b1;
    ready_b = 1'b0;
    @(posedge clk);
    #1;
    rst_b = 1'b0;
    ready_b = 1'b1;
    cyc = 0;
    to = 1'b0;
    while (fin_b !== 1'b1 && !to) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc > 3000) to = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    ready_a = 1'b1;
    ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_a, lv_a, fin_a} !== 3'b000 || gaddr_a !== 6'd0 || laddr_a !== 6'd0 || ldata_a !== 8'h00) begin
      errors++;
      $display("FAIL reset_a: req=%b valid=%b finish=%b gaddr=%0d laddr=%0d data=%h, required all 0",
               req_a, lv_a, fin_a, gaddr_a, laddr_a, ldata_a);
    end
    checks++;
    if ({req_b, lv_b, fin_b} !== 3'b000 || gaddr_b !== 5'd0 || laddr_b !== 5'd0 || ldata_b !== 8'h00) begin
      errors++;
      $display("FAIL reset_b: req=%b valid=%b finish=%b gaddr=%0d laddr=%0d data=%h, required all 0",
               req_b, lv_b, fin_b, gaddr_b, laddr_b, ldata_b);
    end
  endtask

  task automatic test_random_frames();
    bit to;
    int cyc, tot;
    logic [5:0] a0, a1;
    for (int f = 0; f < 3; f++) begin
      // Frame 1 uses a narrow range so equal neighbours are common.
      for (int i = 0; i < NA; i++)
        img_a[i] = (f == 1) ? 8'($urandom_range(100, 103)) : 8'($urandom_range(0, 255));
      run_a(-1, to, cyc, a0, a1);
      checks++;
      if (to || cyc > NA + WA + 6) begin
        errors++;
        $display("FAIL rand_latency f%0d: finish after %0d cycles (timeout=%b), required <= %0d", f, cyc, to, NA + WA + 6);
      end
      for (int i = 0; i < NA; i++) begin
        checks++;
        if (wcnt_a[i] !== 1 || wdat_a[i] !== ref_code(img_a, WA, HA, 0, i)) begin
          errors++;
          $display("FAIL rand_code f%0d addr %0d: writes=%0d data=%h, required 1 write of %h",
                   f, i, wcnt_a[i], wdat_a[i], ref_code(img_a, WA, HA, 0, i));
        end
      end
      repeat (5) @(posedge clk);
      #1;
      tot = 0;
      for (int i = 0; i < NA; i++) tot += wcnt_a[i];
      checks++;
      if (fin_a !== 1'b1 || tot !== NA) begin
        errors++;
        $display("FAIL finish_hold f%0d: finish=%b total writes=%0d, required 1 and %0d", f, fin_a, tot, NA);
      end
    end
  endtask

  task automatic test_ramp_const();
    bit to;
    int cyc;
    logic [5:0] a0, a1;
    for (int i = 0; i < NA; i++) img_a[i] = 8'(i);
    run_a(-1, to, cyc, a0, a1);
    checks++;
    if (to || wdat_a[9] !== 8'hF0 || wdat_a[0] !== 8'h00) begin
      errors++;
      $display("FAIL ramp: addr9=%h addr0=%h timeout=%b, required F0 00 0", wdat_a[9], wdat_a[0], to);
    end
    for (int i = 0; i < NA; i++) begin
      checks++;
      if (wcnt_a[i] !== 1 || wdat_a[i] !== ref_code(img_a, WA, HA, 0, i)) begin
        errors++;
        $display("FAIL ramp_code addr %0d: writes=%0d data=%h, required 1 write of %h",
                 i, wcnt_a[i], wdat_a[i], ref_code(img_a, WA, HA, 0, i));
      end
    end
    for (int i = 0; i < NA; i++) img_a[i] = 8'h55;
    run_a(-1, to, cyc, a0, a1);
    for (int i = 0; i < NA; i++) begin
      checks++;
      if (wcnt_a[i] !== 1 || wdat_a[i] !== ref_code(img_a, WA, HA, 0, i)) begin
        errors++;
        $display("FAIL const_code addr %0d: writes=%0d data=%h, required 1 write of %h",
                 i, wcnt_a[i], wdat_a[i], ref_code(img_a, WA, HA, 0, i));
      end
    end
    checks++;
    if (wdat_a[WA + 1] !== 8'hFF) begin
      errors++;
      $display("FAIL const_interior: data=%h, required FF", wdat_a[WA + 1]);
    end
  endtask

  task automatic test_stall();
    bit to;
    int cyc;
    logic [5:0] a0, a1;
    for (int i = 0; i < NA; i++) img_a[i] = 8'($urandom_range(0, 255));
    stall_bad_a = 0;
    run_a(20, to, cyc, a0, a1);
    checks++;
    if (to || stall_bad_a !== 0 || a0 !== a1) begin
      errors++;
      $display("FAIL stall: timeout=%b activity=%0d addr %0d->%0d, required 0 0 and held address",
               to, stall_bad_a, a0, a1);
    end
    for (int i = 0; i < NA; i++) begin
      checks++;
      if (wcnt_a[i] !== 1 || wdat_a[i] !== ref_code(img_a, WA, HA, 0, i)) begin
        errors++;
        $display("FAIL stall_code addr %0d: writes=%0d data=%h, required 1 write of %h",
                 i, wcnt_a[i], wdat_a[i], ref_code(img_a, WA, HA, 0, i));
      end
    end
  endtask

  task automatic test_border_off();
    bit to;
    int cyc, tot, r, c;
    bit bord;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NB; i++) img_b[i] = (f == 0) ? 8'($urandom_range(0, 7)) : 8'h55;
      run_b(to, cyc);
      tot = 0;
      for (int i = 0; i < NB; i++) tot += wcnt_b[i];
      checks++;
      if (to || tot !== (WB - 2) * (HB - 2)) begin
        errors++;
        $display("FAIL border_off_count f%0d: writes=%0d timeout=%b, required %0d", f, tot, to, (WB - 2) * (HB - 2));
      end
      for (int i = 0; i < NB; i++) begin
        r = i / WB;
        c = i % WB;
        bord = (r == 0 || r == HB - 1 || c == 0 || c == WB - 1);
        checks++;
        if (bord ? (wcnt_b[i] !== 0)
                 : (wcnt_b[i] !== 1 || wdat_b[i] !== ref_code(img_b, WB, HB, TB, i))) begin
          errors++;
          $display("FAIL border_off f%0d addr %0d: writes=%0d data=%h, required %0d writes data %h",
                   f, i, wcnt_b[i], wdat_b[i], bord ? 0 : 1, ref_code(img_b, WB, HB, TB, i));
        end
      end
      checks++;
      if (f == 1 && wdat_b[WB + 1] !== 8'h00) begin
        errors++;
        $display("FAIL const_thresh: data=%h, required 00", wdat_b[WB + 1]);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit to;
    int cyc;
    logic [5:0] a0, a1;
    for (int i = 0; i < NA; i++) img_a[i] = 8'($urandom_range(0, 255));
    rst_a = 1'b1;
    ready_a = 1'b0;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    ready_a = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst_a = 1'b1;
    #1;
    checks++;
    if ({req_a, lv_a, fin_a} !== 3'b000 || gaddr_a !== 6'd0 || laddr_a !== 6'd0 || ldata_a !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: req=%b valid=%b finish=%b gaddr=%0d laddr=%0d data=%h, required all 0",
               req_a, lv_a, fin_a, gaddr_a, laddr_a, ldata_a);
    end
    run_a(-1, to, cyc, a0, a1);
    checks++;
    if (to || cyc <= NA) begin
      errors++;
      $display("FAIL rerun_finish: finish after %0d cycles timeout=%b, required > %0d", cyc, to, NA);
    end
    for (int i = 0; i < NA; i++) begin
      checks++;
      if (wcnt_a[i] !== 1 || wdat_a[i] !== ref_code(img_a, WA, HA, 0, i)) begin
        errors++;
        $display("FAIL rerun_code addr %0d: writes=%0d data=%h, required 1 write of %h",
                 i, wcnt_a[i], wdat_a[i], ref_code(img_a, WA, HA, 0, i));
      end
    end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ready_a = 1'b0;
    ready_b = 1'b0;
    test_reset();
    test_random_frames();
    test_ramp_const();
    test_stall();
    test_border_off();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
